// File: rtl/i2c_write_monitor_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2c_write_monitor_if                                             |
// | Bus lines observed by the monitor plus its received-byte outputs |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface i2c_write_monitor_if;
  logic       i2c_scl_in;
  logic       i2c_sda_in;
  logic [6:0] addr_out;
  logic [7:0] data_out;
  logic       valid_out;
  logic       busy_out;
  logic       error_out;

  modport master (
    output i2c_scl_in, i2c_sda_in,
    input  addr_out, data_out, valid_out, busy_out, error_out
  );

  modport slave (
    input  i2c_scl_in, i2c_sda_in,
    output addr_out, data_out, valid_out, busy_out, error_out
  );
endinterface
`default_nettype wire

// File: rtl/i2c_write_monitor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2c_write_monitor                                                |
// | Passive I2C receiver: decodes START/STOP, address and write data |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module i2c_write_monitor #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter bit         MATCH_ALL   = 1'b0,
  parameter int         SYNC_STAGES = 2
) (
  input  wire logic           clk_in,
  input  wire logic           reset_in,
  i2c_write_monitor_if.slave  bus
);

  localparam int c_stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [2:0] c_st_idle     = 3'd0;
  localparam logic [2:0] c_st_addr     = 3'd1;
  localparam logic [2:0] c_st_addr_ack = 3'd2;
  localparam logic [2:0] c_st_data     = 3'd3;
  localparam logic [2:0] c_st_data_ack = 3'd4;
  localparam logic [2:0] c_st_ignore   = 3'd5;

  logic [c_stages-1:0] r_scl_sync;
  logic [c_stages-1:0] r_sda_sync;
  logic                r_scl_hist;
  logic                r_sda_hist;

  logic [2:0] r_state;
  logic [2:0] w_state_next;
  logic [2:0] r_bit_cnt;
  logic       r_bit_open;
  logic [6:0] r_shift;
  logic       r_rw;
  logic [6:0] r_addr;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_error;
  logic       w_busy;

  logic w_scl;
  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  logic w_in_byte;
  logic w_frame_err;
  logic w_accept;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[c_stages-2:0], bus.i2c_scl_in};
      r_sda_sync <= {r_sda_sync[c_stages-2:0], bus.i2c_sda_in};
      r_scl_hist <= w_scl;
      r_sda_hist <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[c_stages-1];
  assign w_sda      = r_sda_sync[c_stages-1];
  assign w_scl_rise = w_scl & ~r_scl_hist;
  assign w_scl_fall = ~w_scl & r_scl_hist;
  // SCL must be high on both sides, so a coincident SCL edge never yields START/STOP.
  assign w_start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
  assign w_stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;
  assign w_in_byte  = (r_state == c_st_addr) || (r_state == c_st_data);
  // A bit whose SCL is still high is not yet complete: the rising edge that
  // precedes a STOP or repeated START must not count as a received bit.
  assign w_frame_err = (w_start || w_stop) && w_in_byte &&
                       (r_bit_cnt != {2'b00, r_bit_open});
  assign w_accept   = ~r_rw && (MATCH_ALL || (r_addr == SLAVE_ADDR));

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_start) begin
      w_state_next = c_st_addr;
    end else if (w_stop) begin
      w_state_next = c_st_idle;
    end else if (w_scl_rise) begin
      case (r_state)
        c_st_addr:     if (r_bit_cnt == 3'd7) w_state_next = c_st_addr_ack;
        c_st_addr_ack: w_state_next = w_accept ? c_st_data : c_st_ignore;
        c_st_data:     if (r_bit_cnt == 3'd7) w_state_next = c_st_data_ack;
        c_st_data_ack: w_state_next = c_st_data;
        default:       w_state_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_busy = (r_state != c_st_idle);
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_bit_cnt  <= 3'd0;
      r_bit_open <= 1'b0;
      r_shift    <= 7'd0;
      r_rw       <= 1'b0;
      r_addr     <= 7'd0;
      r_data     <= 8'd0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_error <= w_frame_err;
      if (w_start || w_stop) begin
        r_bit_cnt  <= 3'd0;
        r_bit_open <= 1'b0;
      end else if (w_scl_rise && w_in_byte) begin
        r_shift <= {r_shift[5:0], w_sda};
        if (r_bit_cnt == 3'd7) begin
          r_bit_cnt  <= 3'd0;
          r_bit_open <= 1'b0;
          if (r_state == c_st_addr) begin
            r_addr <= r_shift;
            r_rw   <= w_sda;
          end else begin
            r_data  <= {r_shift, w_sda};
            r_valid <= 1'b1;
          end
        end else begin
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          r_bit_open <= 1'b1;
        end
      end else if (w_scl_fall) begin
        r_bit_open <= 1'b0;
      end
    end
  end

  assign bus.addr_out  = r_addr;
  assign bus.data_out  = r_data;
  assign bus.valid_out = r_valid;
  assign bus.busy_out  = w_busy;
  assign bus.error_out = r_error;

endmodule
`default_nettype wire

// File: tb/tb_i2c_write_monitor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_i2c_write_monitor                                             |
// | Randomised I2C master stimulus against a frame-level model       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_i2c_write_monitor;
  localparam int         Q       = 3;
  localparam logic [6:0] C_SLAVE = 7'h50;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic scl   = 1'b1;
  logic sda   = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [14:0] q_a[$];
  logic [14:0] q_b[$];
  logic [14:0] exp_a[$];
  logic [14:0] exp_b[$];
  logic [7:0]  tx[$];
  int          err_a = 0;
  int          err_b = 0;

  always #5 clk = ~clk;

  i2c_write_monitor_if if_a ();
  i2c_write_monitor_if if_b ();

  assign if_a.i2c_scl_in = scl;
  assign if_a.i2c_sda_in = sda;
  assign if_b.i2c_scl_in = scl;
  assign if_b.i2c_sda_in = sda;

  i2c_write_monitor #(.SLAVE_ADDR(C_SLAVE), .MATCH_ALL(1'b0), .SYNC_STAGES(2)) dut_a (
    .clk_in   (clk),
    .reset_in (rst_n),
    .bus      (if_a)
  );

  i2c_write_monitor #(.SLAVE_ADDR(C_SLAVE), .MATCH_ALL(1'b1), .SYNC_STAGES(2)) dut_b (
    .clk_in   (clk),
    .reset_in (rst_n),
    .bus      (if_b)
  );

  // Log every valid/error cycle; a pulse longer than one cycle logs twice.
  always @(negedge clk) begin
    if (if_a.valid_out === 1'b1) q_a.push_back({if_a.addr_out, if_a.data_out});
    if (if_b.valid_out === 1'b1) q_b.push_back({if_b.addr_out, if_b.data_out});
    if (if_a.error_out === 1'b1) err_a++;
    if (if_b.error_out === 1'b1) err_b++;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    sda = 1'b0; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda = 1'b0; wait_q();
    scl = 1'b1; wait_q();
    sda = 1'b1; wait_q(); wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda = b;    wait_q();
    scl = 1'b1; wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [6:0] addr, input logic rw);
    i2c_start();
    send_byte({addr, rw});
    foreach (tx[i]) send_byte(tx[i]);
  endtask

  // Frame-level expectation: write bytes are delivered only for an accepted address.
  task automatic model_frame(input logic [6:0] addr, input logic rw);
    foreach (tx[i]) begin
      if (!rw && addr == C_SLAVE) exp_a.push_back({addr, tx[i]});
      if (!rw) exp_b.push_back({addr, tx[i]});
    end
  endtask

  task automatic clear_logs();
    q_a.delete(); q_b.delete(); exp_a.delete(); exp_b.delete(); tx.delete();
    err_a = 0; err_b = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (if_a.addr_out !== 7'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", if_a.addr_out); end
    checks++; if (if_a.data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", if_a.data_out); end
    checks++; if (if_a.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_a.valid_out); end
    checks++; if (if_a.busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", if_a.busy_out); end
    checks++; if (if_a.error_out !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", if_a.error_out); end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (if_a.busy_out !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy got %b expected 0", if_a.busy_out); end
  endtask

  task automatic test_single_write();
    clear_logs();
    i2c_start();
    repeat (2) @(negedge clk);
    checks++; if (if_a.busy_out !== 1'b1) begin errors++; $display("FAIL single_busy_start: got %b expected 1", if_a.busy_out); end
    send_byte({C_SLAVE, 1'b0});
    send_byte(8'hA5);
    checks++; if (if_a.busy_out !== 1'b1) begin errors++; $display("FAIL single_busy_mid: got %b expected 1", if_a.busy_out); end
    i2c_stop();
    checks++; if (if_a.busy_out !== 1'b0) begin errors++; $display("FAIL single_busy_stop: got %b expected 0", if_a.busy_out); end
    checks++; if (q_a.size() !== 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", q_a.size()); end
    checks++; if ((q_a.size() > 0 ? q_a[0] : 15'hx) !== {7'h50, 8'hA5}) begin errors++; $display("FAIL single_byte: got %h expected %h", (q_a.size() > 0 ? q_a[0] : 15'hx), {7'h50, 8'hA5}); end
    checks++; if (if_a.addr_out !== 7'h50) begin errors++; $display("FAIL single_addr: got %h expected 50", if_a.addr_out); end
    checks++; if (if_a.data_out !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", if_a.data_out); end
    checks++; if (err_a !== 0) begin errors++; $display("FAIL single_error: got %0d pulses expected 0", err_a); end
  endtask

  task automatic test_addr_mismatch();
    clear_logs();
    tx.push_back(8'h5A);
    send_frame(7'h51, 1'b0);
    checks++; if (if_a.busy_out !== 1'b1) begin errors++; $display("FAIL mismatch_busy: got %b expected 1", if_a.busy_out); end
    i2c_stop();
    checks++; if (if_a.busy_out !== 1'b0) begin errors++; $display("FAIL mismatch_busy_stop: got %b expected 0", if_a.busy_out); end
    checks++; if (q_a.size() !== 0) begin errors++; $display("FAIL mismatch_pulses: got %0d expected 0", q_a.size()); end
    checks++; if (if_a.addr_out !== 7'h51) begin errors++; $display("FAIL mismatch_addr: got %h expected 51", if_a.addr_out); end
    checks++; if (q_b.size() !== 1) begin errors++; $display("FAIL matchall_pulses: got %0d expected 1", q_b.size()); end
    checks++; if ((q_b.size() > 0 ? q_b[0] : 15'hx) !== {7'h51, 8'h5A}) begin errors++; $display("FAIL matchall_byte: got %h expected %h", (q_b.size() > 0 ? q_b[0] : 15'hx), {7'h51, 8'h5A}); end
  endtask

  task automatic test_multi_byte();
    clear_logs();
    tx.push_back(8'h01); tx.push_back(8'hFF); tx.push_back(8'h80);
    model_frame(C_SLAVE, 1'b0);
    send_frame(C_SLAVE, 1'b0);
    i2c_stop();
    checks++; if (q_a.size() !== exp_a.size()) begin errors++; $display("FAIL multi_pulses: got %0d expected %0d", q_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size(); i++) begin
      checks++;
      if ((i < q_a.size() ? q_a[i] : 15'hx) !== exp_a[i]) begin errors++; $display("FAIL multi_byte%0d: got %h expected %h", i, (i < q_a.size() ? q_a[i] : 15'hx), exp_a[i]); end
    end
    checks++; if (err_a !== 0) begin errors++; $display("FAIL multi_error: got %0d expected 0", err_a); end
  endtask

  task automatic test_read_frame();
    clear_logs();
    tx.push_back(8'hC3);
    send_frame(C_SLAVE, 1'b1);
    checks++; if (if_a.busy_out !== 1'b1) begin errors++; $display("FAIL read_busy: got %b expected 1", if_a.busy_out); end
    i2c_stop();
    checks++; if (if_a.busy_out !== 1'b0) begin errors++; $display("FAIL read_busy_stop: got %b expected 0", if_a.busy_out); end
    checks++; if (q_a.size() + q_b.size() !== 0) begin errors++; $display("FAIL read_pulses: got %0d expected 0", q_a.size() + q_b.size()); end
    checks++; if (err_a !== 0) begin errors++; $display("FAIL read_error: got %0d expected 0", err_a); end
  endtask

  task automatic test_stop_error();
    clear_logs();
    i2c_start();
    send_byte({C_SLAVE, 1'b0});
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    i2c_stop();
    checks++; if (err_a !== 1) begin errors++; $display("FAIL stop_err_pulses: got %0d expected 1", err_a); end
    checks++; if (q_a.size() !== 0) begin errors++; $display("FAIL stop_err_valid: got %0d expected 0", q_a.size()); end
    checks++; if (if_a.busy_out !== 1'b0) begin errors++; $display("FAIL stop_err_idle: busy got %b expected 0", if_a.busy_out); end
    tx.push_back(8'h96);
    send_frame(C_SLAVE, 1'b0);
    i2c_stop();
    checks++; if ((q_a.size() == 1 ? q_a[0] : 15'hx) !== {C_SLAVE, 8'h96}) begin errors++; $display("FAIL stop_err_recover: got %h expected %h", (q_a.size() == 1 ? q_a[0] : 15'hx), {C_SLAVE, 8'h96}); end
    checks++; if (err_a !== 1) begin errors++; $display("FAIL stop_err_extra: got %0d expected 1", err_a); end
  endtask

  task automatic test_reset_mid_data();
    clear_logs();
    i2c_start();
    send_byte({C_SLAVE, 1'b0});
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (if_a.addr_out !== 7'h00) begin errors++; $display("FAIL rst_mid_addr: got %h expected 00", if_a.addr_out); end
    checks++; if (if_a.data_out !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h expected 00", if_a.data_out); end
    checks++; if (if_a.busy_out !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", if_a.busy_out); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b1);
    checks++; if (if_a.busy_out !== 1'b0) begin errors++; $display("FAIL rst_mid_ignore: busy got %b expected 0", if_a.busy_out); end
    i2c_stop();
    tx.push_back(8'h3C);
    send_frame(C_SLAVE, 1'b0);
    i2c_stop();
    checks++; if (q_a.size() !== 1) begin errors++; $display("FAIL rst_mid_pulses: got %0d expected 1", q_a.size()); end
    checks++; if ((q_a.size() > 0 ? q_a[0] : 15'hx) !== {C_SLAVE, 8'h3C}) begin errors++; $display("FAIL rst_mid_byte: got %h expected %h", (q_a.size() > 0 ? q_a[0] : 15'hx), {C_SLAVE, 8'h3C}); end
    checks++; if (err_a !== 0) begin errors++; $display("FAIL rst_mid_error: got %0d expected 0", err_a); end
  endtask

  // Random frames; about half are chained with a repeated START instead of a STOP.
  task automatic test_back_to_back();
    logic [6:0] addr;
    logic       rw;
    int         nb;
    clear_logs();
    for (int f = 0; f < 14; f++) begin
      tx.delete();
      addr = ($urandom_range(0, 1) == 1) ? C_SLAVE : 7'($urandom_range(0, 127));
      rw   = ($urandom_range(0, 3) == 0);
      nb   = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) tx.push_back(8'($urandom));
      model_frame(addr, rw);
      send_frame(addr, rw);
      if ($urandom_range(0, 1) == 1 || f == 13) i2c_stop();
      checks++; if (if_b.addr_out !== addr) begin errors++; $display("FAIL rand_addr f%0d: got %h expected %h", f, if_b.addr_out, addr); end
    end
    checks++; if (q_a.size() !== exp_a.size()) begin errors++; $display("FAIL rand_count_a: got %0d expected %0d", q_a.size(), exp_a.size()); end
    checks++; if (q_b.size() !== exp_b.size()) begin errors++; $display("FAIL rand_count_b: got %0d expected %0d", q_b.size(), exp_b.size()); end
    for (int i = 0; i < exp_a.size(); i++) begin
      checks++;
      if ((i < q_a.size() ? q_a[i] : 15'hx) !== exp_a[i]) begin errors++; $display("FAIL rand_a%0d: got %h expected %h", i, (i < q_a.size() ? q_a[i] : 15'hx), exp_a[i]); end
    end
    for (int i = 0; i < exp_b.size(); i++) begin
      checks++;
      if ((i < q_b.size() ? q_b[i] : 15'hx) !== exp_b[i]) begin errors++; $display("FAIL rand_b%0d: got %h expected %h", i, (i < q_b.size() ? q_b[i] : 15'hx), exp_b[i]); end
    end
    checks++; if (err_a + err_b !== 0) begin errors++; $display("FAIL rand_error: got %0d expected 0", err_a + err_b); end
    checks++; if (if_a.busy_out !== 1'b0) begin errors++; $display("FAIL rand_busy_end: got %b expected 0", if_a.busy_out); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_addr_mismatch();
    test_multi_byte();
    test_read_frame();
    test_stop_error();
    test_reset_mid_data();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_write_monitor.md
Name: i2c_write_monitor

Overview:
- Passive I2C receiver that sits directly downstream of the FIFO-fed I2C master.
- Observes the master's SCL/SDA outputs, detects START/STOP, and deserialises the 7-bit address, R/W bit and data bytes.
- Presents each received write byte to the fabric as a one-cycle valid pulse.
- Serves as the device-side model/consumer for loopback and for on-chip capture of master writes; never drives the bus.

Parameters:
- SLAVE_ADDR, 7'h50, address this block accepts writes for.
- MATCH_ALL, 0, when 1 every address is accepted (monitor mode).
- SYNC_STAGES, 2, flip-flop synchroniser depth on SCL and SDA (min 2).

Ports:
- clk_in  input  1  system clock; at least 8x SCL frequency.
- reset_in  input  1  reset, asynchronous, active-low.
- i2c_scl_in  input  1  bus SCL, asynchronous to clk_in.
- i2c_sda_in  input  1  bus SDA, asynchronous to clk_in.
- addr_out  output  7  address of current/last frame, held until next START.
- data_out  output  8  last received data byte, held until next byte.
- valid_out  output  1  one-cycle pulse: data_out/addr_out carry a new accepted write byte.
- busy_out  output  1  high from START detect to STOP detect.
- error_out  output  1  one-cycle pulse on framing error.

Behaviour:
- Reset: all outputs 0, FSM IDLE, bit counter 0, synchroniser and edge-history flops all 1 (bus idle).
- Synchronise SCL and SDA through SYNC_STAGES flops. All edge and condition detection uses synchronised values plus one history flop. Input-to-detect latency is SYNC_STAGES+1 cycles.
- START: sync SDA 1->0 while sync SCL high. STOP: sync SDA 0->1 while sync SCL high. Data bits are sampled on sync SCL rising edge only.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE: START -> ADDR, bit_cnt=0, busy_out=1.
  - ADDR: shift 8 bits MSB first (7 address + R/W). On the 8th rising edge, load addr_out, go to ADDR_ACK.
  - ADDR_ACK: consume the 9th SCL rising edge (ACK value ignored). Next state is DATA if R/W=0 and (addr==SLAVE_ADDR or MATCH_ALL), else IGNORE.
  - DATA: shift 8 bits MSB first. On the 8th rising edge, data_out <= shifted byte and valid_out=1 for exactly the next clk cycle, then go to DATA_ACK.
  - DATA_ACK: consume the 9th rising edge, return to DATA with bit_cnt=0. Multi-byte writes are allowed; each byte pulses valid_out once.
  - IGNORE: no pulses; wait for START/STOP.
- STOP in any state -> IDLE, busy_out=0 on the cycle after detection.
- Repeated START in any non-IDLE state -> ADDR, bit_cnt=0, busy_out stays 1.
- Framing error: START or STOP detected in ADDR or DATA with bit_cnt in 1..7. Pulse error_out one cycle, discard the partial byte (no valid_out), then take the START/STOP transition. START/STOP at bit_cnt=0 or in an ACK state is not an error.
- bit_cnt is 3 bits and saturates logic by state transition; it never wraps silently.
- Simultaneous SCL and SDA change in the same synchronised cycle: treat as SCL edge only; no START/STOP is flagged.
- Reset asserted mid-frame: immediate return to reset values. After release, wait for a fresh START even if the bus is mid-byte.

Test Plan:
- Write addr 7'h50, data 8'hA5, STOP -> one valid_out pulse, addr_out=7'h50, data_out=8'hA5; busy_out high START..STOP; error_out never set.
- Write to 7'h51 with MATCH_ALL=0 -> no valid_out, addr_out=7'h51, busy_out toggles; rerun with MATCH_ALL=1 -> valid_out with data.
- Multi-byte write 7'h50: 8'h01, 8'hFF, 8'h80 -> exactly three valid_out pulses, data_out 01/FF/80 in order.
- Read frame (7'h50, R/W=1) -> IGNORE state, no valid_out, busy_out drops on STOP.
- STOP injected after 3 data bits -> error_out one pulse, no valid_out, FSM IDLE; next full frame received correctly.
- reset_in low for 2 cycles mid-DATA -> outputs 0 immediately. Remaining bits ignored until the next START; the following 7'h50/8'h3C frame yields a single valid_out with 8'h3C.
